tm_exec: RTL and testbench
==========================

Name: tm_exec

Overview:
- Turing-machine execution controller that sits directly upstream of the tape unit and drives its move handshake.
- Each step it reads the current head symbol and looks up the transition rule {state, symbol} through an external rule-memory handshake.
- It then commands the tape to write the new symbol and move left or right, and advances the machine state.
- It also handles run, pause and single-step control, step counting, halting and step-limit timeout.

Parameters:
- STATE_BITS, 4, width of the machine-state register; the rule word is RULE_W = 10 + STATE_BITS bits.
- CNT_BITS, 24, width of the step counter and the step-limit input.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  pulse; begins a run from start_state_i; honoured only in IDLE or HALTED
- run_i  in  1  level; 1 = free-run, 0 = pause at the next step boundary
- step_i  in  1  pulse; executes exactly one step while paused
- start_state_i  in  STATE_BITS  initial machine state
- max_steps_i  in  CNT_BITS  step limit; 0 = unlimited
- rule_req_o  out  1  rule lookup request
- rule_addr_o  out  STATE_BITS+8  {cur_state, symbol}
- rule_ack_i  in  1  rule_data_i valid this cycle
- rule_data_i  in  RULE_W  [7:0] write symbol, [8] dir (1 = right), [9] halt, [9+STATE_BITS:10] next state
- tape_data_i  in  8  symbol under the head
- tape_valid_i  in  1  tape_data_i valid
- tape_move_o  out  1  move request
- tape_move_dir_o  out  1  1 = right, 0 = left
- tape_move_data_o  out  8  symbol to write at the current head position before moving
- tape_move_done_i  in  1  one-cycle move-complete pulse
- state_o  out  STATE_BITS  current machine state
- step_count_o  out  CNT_BITS  steps completed
- busy_o  out  1  high in any state except IDLE and HALTED
- halted_o  out  1  high in HALTED
- timeout_o  out  1  sticky; set when the step limit ends a run

Behaviour:
- Reset values: FSM = IDLE; all outputs 0; cur_state = 0; step_count = 0; internal rule latch = 0.
- A reset mid-step drops rule_req_o and tape_move_o immediately (asynchronous).
- FSM states: IDLE, WAIT_SYM, RULE, MOVE, HALTED.
- IDLE / HALTED, on start_i:
  - cur_state <= start_state_i; step_count <= 0; timeout_o <= 0; go WAIT_SYM.
  - start_i in any other state is ignored.
- WAIT_SYM (step boundary):
  - Proceeds only if tape_valid_i && (run_i || step_i).
  - On proceeding: latch sym <= tape_data_i; rule_req_o <= 1; go RULE.
  - step_i seen while tape_valid_i is low is lost.
  - If max_steps_i != 0 && step_count == max_steps_i, go HALTED with timeout_o <= 1. This check takes priority over proceeding.
- RULE:
  - rule_req_o and rule_addr_o stay stable until rule_ack_i.
  - On ack: latch rule_data_i; rule_req_o <= 0.
  - If halt bit = 1: go HALTED; no write, no move, step_count unchanged.
  - If halt bit = 0: tape_move_o <= 1 with dir and data from the rule; go MOVE.
  - Ack in the same cycle the request rises is legal; the earliest sample is the cycle after RULE entry.
- MOVE:
  - tape_move_o, tape_move_dir_o and tape_move_data_o stay stable while tape_move_o = 1.
  - dir and data stay valid through the cycle tape_move_done_i is high; the tape samples dir in that cycle.
  - On tape_move_done_i: tape_move_o <= 0; cur_state <= next state; step_count += 1, saturating at all-ones; go WAIT_SYM.
  - tape_move_o must be low by the edge after done, so the tape does not re-trigger a move.
- Throughput floor: 4 cycles per step (WAIT_SYM, RULE with immediate ack, MOVE, done). Real rate is bounded by the tape.
- tape_move_done_i outside MOVE and rule_ack_i outside RULE are ignored.
- run_i falling mid-step never aborts the step; the FSM pauses in WAIT_SYM.
- state_o = cur_state.

Test Plan:
- Reset; start_i with start_state_i = 3, run_i = 1, tape_valid_i = 1, data 0x00, rule {next = 5, dir = 1, wr = 0x41, halt = 0} acked immediately.
  -> rule_addr_o = 0x300; tape_move_o with dir 1 and data 0x41 held until done; then state_o = 5, step_count_o = 1.
- Rule with halt = 1 in state 5.
  -> no tape_move_o; halted_o = 1; busy_o = 0; step_count_o unchanged; a new start_i restarts with count 0.
- max_steps_i = 3 with a looping non-halting rule.
  -> exactly 3 moves, then HALTED with timeout_o = 1 and step_count_o = 3.
- run_i = 0, then two step_i pulses 10 cycles apart.
  -> exactly one move per pulse; the FSM parks in WAIT_SYM between pulses.
- tape_valid_i low for 20 cycles and rule_ack_i delayed 7 cycles.
  -> no rule_req_o before valid; rule_addr_o stable for all 7 cycles.
- Tape done delayed 50 cycles, then rst_n asserted mid-MOVE.
  -> tape_move_o drops asynchronously; all outputs return to reset values.

Source files
------------

// File: rtl/tm_exec.sv
// tm_exec: Turing-machine step controller; looks up {state, symbol} rules and
// drives the tape move handshake, with run/pause/single-step, halt and step limit.
module tm_exec #(
   parameter int STATE_BITS = 4,
   parameter int CNT_BITS   = 24
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start_i,
   input  logic                     run_i,
   input  logic                     step_i,
   input  logic [STATE_BITS-1:0]    start_state_i,
   input  logic [CNT_BITS-1:0]      max_steps_i,
   output logic                     rule_req_o,
   output logic [STATE_BITS+7:0]    rule_addr_o,
   input  logic                     rule_ack_i,
   input  logic [STATE_BITS+9:0]    rule_data_i,
   input  logic [7:0]               tape_data_i,
   input  logic                     tape_valid_i,
   output logic                     tape_move_o,
   output logic                     tape_move_dir_o,
   output logic [7:0]               tape_move_data_o,
   input  logic                     tape_move_done_i,
   output logic [STATE_BITS-1:0]    state_o,
   output logic [CNT_BITS-1:0]      step_count_o,
   output logic                     busy_o,
   output logic                     halted_o,
   output logic                     timeout_o
);
   localparam int RULE_W = 10 + STATE_BITS;
   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_RULE   = 3'd2;
   localparam logic [2:0] S_MOVE   = 3'd3;
   localparam logic [2:0] S_HALTED = 3'd4;

   logic [2:0]            fsm_q, fsm_d;
   logic [STATE_BITS-1:0] cur_q, cur_d;
   logic [CNT_BITS-1:0]   cnt_q, cnt_d;
   logic [7:0]            sym_q, sym_d;
   logic [RULE_W-1:0]     rule_q, rule_d;
   logic                  req_q, req_d;
   logic                  move_q, move_d;
   logic                  tmo_q, tmo_d;

   always_comb begin
      fsm_d  = fsm_q;
      cur_d  = cur_q;
      cnt_d  = cnt_q;
      sym_d  = sym_q;
      rule_d = rule_q;
      req_d  = req_q;
      move_d = move_q;
      tmo_d  = tmo_q;
      case (fsm_q)
         S_IDLE, S_HALTED:
            if (start_i) begin
               cur_d = start_state_i;
               cnt_d = '0;
               tmo_d = 1'b0;
               fsm_d = S_WAIT;
            end
         S_WAIT:
            // The step limit wins over starting another step.
            if (max_steps_i != '0 && cnt_q == max_steps_i) begin
               tmo_d = 1'b1;
               fsm_d = S_HALTED;
            end else if (tape_valid_i && (run_i || step_i)) begin
               sym_d = tape_data_i;
               req_d = 1'b1;
               fsm_d = S_RULE;
            end
         S_RULE:
            if (rule_ack_i) begin
               rule_d = rule_data_i;
               req_d  = 1'b0;
               if (rule_data_i[9]) begin
                  fsm_d = S_HALTED;
               end else begin
                  move_d = 1'b1;
                  fsm_d  = S_MOVE;
               end
            end
         S_MOVE:
            if (tape_move_done_i) begin
               move_d = 1'b0;
               cur_d  = rule_q[RULE_W-1:10];
               cnt_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_BITS'(1);
               fsm_d  = S_WAIT;
            end
         default: fsm_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q  <= S_IDLE;
         cur_q  <= '0;
         cnt_q  <= '0;
         sym_q  <= '0;
         rule_q <= '0;
         req_q  <= 1'b0;
         move_q <= 1'b0;
         tmo_q  <= 1'b0;
      end else begin
         fsm_q  <= fsm_d;
         cur_q  <= cur_d;
         cnt_q  <= cnt_d;
         sym_q  <= sym_d;
         rule_q <= rule_d;
         req_q  <= req_d;
         move_q <= move_d;
         tmo_q  <= tmo_d;
      end
   end

   assign rule_req_o       = req_q;
   assign rule_addr_o      = {cur_q, sym_q};
   assign tape_move_o      = move_q;
   assign tape_move_dir_o  = rule_q[8];
   assign tape_move_data_o = rule_q[7:0];
   assign state_o          = cur_q;
   assign step_count_o     = cnt_q;
   assign halted_o         = fsm_q == S_HALTED;
   assign busy_o           = fsm_q != S_IDLE && fsm_q != S_HALTED;
   assign timeout_o        = tmo_q;
endmodule

// File: tb/tb_tm_exec.sv
// tb_tm_exec: directed bench for tm_exec with hand-computed expectations.
module tb_tm_exec;
   localparam int SB = 4;
   localparam int CB = 24;
   localparam int RW = 14;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_i = 1'b0, run_i = 1'b0, step_i = 1'b0;
   logic [SB-1:0] start_state_i = '0;
   logic [CB-1:0] max_steps_i = '0;
   logic          rule_req_o;
   logic [SB+7:0] rule_addr_o;
   logic          rule_ack_i = 1'b0;
   logic [RW-1:0] rule_data_i = '0;
   logic [7:0]    tape_data_i = '0;
   logic          tape_valid_i = 1'b0;
   logic          tape_move_o, tape_move_dir_o;
   logic [7:0]    tape_move_data_o;
   logic          tape_move_done_i = 1'b0;
   logic [SB-1:0] state_o;
   logic [CB-1:0] step_count_o;
   logic          busy_o, halted_o, timeout_o;

   int n_cmp = 0, n_err = 0, moves = 0, m0, bad;

   tm_exec #(.STATE_BITS(SB), .CNT_BITS(CB)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .run_i(run_i), .step_i(step_i),
      .start_state_i(start_state_i), .max_steps_i(max_steps_i),
      .rule_req_o(rule_req_o), .rule_addr_o(rule_addr_o), .rule_ack_i(rule_ack_i),
      .rule_data_i(rule_data_i), .tape_data_i(tape_data_i), .tape_valid_i(tape_valid_i),
      .tape_move_o(tape_move_o), .tape_move_dir_o(tape_move_dir_o),
      .tape_move_data_o(tape_move_data_o), .tape_move_done_i(tape_move_done_i),
      .state_o(state_o), .step_count_o(step_count_o), .busy_o(busy_o),
      .halted_o(halted_o), .timeout_o(timeout_o)
   );

   always #5 clk = ~clk;

   // Completed moves, as the tape would see them.
   always @(posedge clk) if (tape_move_o && tape_move_done_i) moves <= moves + 1;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
      end
   endtask

   task automatic pulse_start(input logic [SB-1:0] s);
      start_state_i = s;
      start_i = 1'b1;
      @(negedge clk);
      start_i = 1'b0;
   endtask

   task automatic wait_req(input string tag);
      int n = 0;
      while (!rule_req_o && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk(tag, rule_req_o, 1);
   endtask

   task automatic wait_move(input string tag);
      int n = 0;
      while (!tape_move_o && n < 40) begin
         @(negedge clk);
         n++;
      end
      chk(tag, tape_move_o, 1);
   endtask

   task automatic do_step(input logic [RW-1:0] r, input int done_dly);
      wait_req("step_req");
      rule_data_i = r;
      rule_ack_i = 1'b1;
      @(negedge clk);
      rule_ack_i = 1'b0;
      wait_move("step_move");
      repeat (done_dly) @(negedge clk);
      tape_move_done_i = 1'b1;
      @(negedge clk);
      tape_move_done_i = 1'b0;
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_state", state_o, 0);
      chk("rst_count", step_count_o, 0);
      chk("rst_busy", busy_o, 0);
      chk("rst_halted", halted_o, 0);
      chk("rst_req", rule_req_o, 0);
      chk("rst_move", tape_move_o, 0);
      chk("rst_data", tape_move_data_o, 0);
      rst_n = 1'b1;
      @(negedge clk);

      // Basic step: state 3, symbol 0x00 -> write 0x41, right, state 5
      run_i = 1'b1;
      tape_valid_i = 1'b1;
      tape_data_i = 8'h00;
      pulse_start(4'd3);
      chk("t1_busy", busy_o, 1);
      chk("t1_state", state_o, 3);
      wait_req("t1_req");
      chk("t1_addr", rule_addr_o, 12'h300);
      rule_data_i = {4'd5, 1'b0, 1'b1, 8'h41};
      rule_ack_i = 1'b1;
      @(negedge clk);
      rule_ack_i = 1'b0;
      chk("t1_req_drop", rule_req_o, 0);
      chk("t1_move", tape_move_o, 1);
      chk("t1_dir", tape_move_dir_o, 1);
      chk("t1_wdata", tape_move_data_o, 8'h41);
      repeat (3) @(negedge clk);
      chk("t1_move_hold", tape_move_o, 1);
      chk("t1_wdata_hold", tape_move_data_o, 8'h41);
      tape_data_i = 8'h07;
      tape_move_done_i = 1'b1;
      chk("t1_dir_at_done", tape_move_dir_o, 1);
      @(negedge clk);
      tape_move_done_i = 1'b0;
      chk("t1_move_low", tape_move_o, 0);
      chk("t1_next_state", state_o, 5);
      chk("t1_count", step_count_o, 1);

      // Halting rule in state 5
      wait_req("t2_req");
      chk("t2_addr", rule_addr_o, 12'h507);
      rule_data_i = {4'd9, 1'b1, 1'b0, 8'hAA};
      rule_ack_i = 1'b1;
      @(negedge clk);
      rule_ack_i = 1'b0;
      chk("t2_halted", halted_o, 1);
      chk("t2_busy", busy_o, 0);
      chk("t2_timeout", timeout_o, 0);
      chk("t2_count", step_count_o, 1);
      chk("t2_state", state_o, 5);
      repeat (3) @(negedge clk);
      chk("t2_no_move", tape_move_o, 0);
      chk("t2_moves", moves, 1);

      // Step limit of 3 with a self-looping rule
      m0 = moves;
      max_steps_i = 24'd3;
      tape_data_i = 8'h11;
      pulse_start(4'd2);
      chk("t3_restart_count", step_count_o, 0);
      chk("t3_halted_clr", halted_o, 0);
      for (int i = 0; i < 3; i++) do_step({4'd2, 1'b0, 1'b0, 8'h55}, 1);
      @(negedge clk);
      chk("t3_halted", halted_o, 1);
      chk("t3_timeout", timeout_o, 1);
      chk("t3_count", step_count_o, 3);
      chk("t3_moves", moves - m0, 3);
      chk("t3_no_req", rule_req_o, 0);

      // Paused: one move per step_i pulse
      run_i = 1'b0;
      max_steps_i = '0;
      pulse_start(4'd2);
      chk("t4_timeout_clr", timeout_o, 0);
      repeat (5) @(negedge clk);
      chk("t4_parked", rule_req_o, 0);
      m0 = moves;
      for (int p = 1; p <= 2; p++) begin
         step_i = 1'b1;
         @(negedge clk);
         step_i = 1'b0;
         do_step({4'd2, 1'b0, 1'b0, 8'h55}, 2);
         repeat (10) @(negedge clk);
         chk("t4_moves", moves - m0, p);
         chk("t4_count", step_count_o, p);
         chk("t4_idle_req", rule_req_o, 0);
         chk("t4_busy", busy_o, 1);
      end

      // step_i while the tape is not valid is lost
      tape_valid_i = 1'b0;
      step_i = 1'b1;
      @(negedge clk);
      step_i = 1'b0;
      tape_valid_i = 1'b1;
      repeat (5) @(negedge clk);
      chk("t5_lost_step", rule_req_o, 0);

      // Invalid tape for 20 cycles, then a rule ack delayed 7 cycles
      tape_valid_i = 1'b0;
      tape_data_i = 8'h3C;
      run_i = 1'b1;
      bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (rule_req_o) bad++;
      end
      chk("t5_no_req_invalid", bad, 0);
      tape_valid_i = 1'b1;
      wait_req("t5_req");
      chk("t5_addr", rule_addr_o, 12'h23C);
      bad = 0;
      repeat (7) begin
         @(negedge clk);
         if (!rule_req_o || rule_addr_o !== 12'h23C) bad++;
      end
      chk("t5_addr_hold", bad, 0);
      rule_data_i = {4'd7, 1'b0, 1'b1, 8'h99};
      rule_ack_i = 1'b1;
      @(negedge clk);
      rule_ack_i = 1'b0;
      chk("t5_move", tape_move_o, 1);

      // Tape stalls 50 cycles, then reset lands mid-move
      m0 = moves;
      bad = 0;
      repeat (50) begin
         @(negedge clk);
         if (!tape_move_o || !tape_move_dir_o || tape_move_data_o !== 8'h99) bad++;
      end
      chk("t6_move_hold", bad, 0);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_async_move", tape_move_o, 0);
      chk("t6_async_req", rule_req_o, 0);
      @(negedge clk);
      chk("t6_state", state_o, 0);
      chk("t6_count", step_count_o, 0);
      chk("t6_busy", busy_o, 0);
      chk("t6_halted", halted_o, 0);
      chk("t6_timeout", timeout_o, 0);
      chk("t6_dir", tape_move_dir_o, 0);
      chk("t6_wdata", tape_move_data_o, 0);
      chk("t6_addr", rule_addr_o, 0);
      chk("t6_moves", moves - m0, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("t6_stay_idle", busy_o, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
